// File: rtl/bus_arbiter_if.sv
// Signal bundle for the shared 8-bit data bus: four sources, four destinations, one arbiter.
// The arbiter connects through the slave modport; the attached modules use master.
interface bus_arbiter_if;
    localparam int unsigned N_PORTS = 4;
    localparam int unsigned BYTE_W  = 8;

    logic [N_PORTS-1:0]        req;
    logic [N_PORTS-1:0]        src_valid;
    logic [N_PORTS-1:0]        src_last;
    logic [N_PORTS*BYTE_W-1:0] src_data;
    logic [N_PORTS-1:0]        src_ready;
    logic [N_PORTS-1:0]        grant;
    logic [BYTE_W-1:0]         bus_data;
    logic [N_PORTS-1:0]        dst_valid;
    logic [N_PORTS-1:0]        dst_ready;
    logic                      busy;
    logic                      timeout_err;

    // Attached sources/destinations
    modport master (
        output req,
        output src_valid,
        output src_last,
        output src_data,
        output dst_ready,
        input  src_ready,
        input  grant,
        input  bus_data,
        input  dst_valid,
        input  busy,
        input  timeout_err
    );

    // Arbiter
    modport slave (
        input  req,
        input  src_valid,
        input  src_last,
        input  src_data,
        input  dst_ready,
        output src_ready,
        output grant,
        output bus_data,
        output dst_valid,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared 8-bit bus: grants one source,
// routes its bytes to the Gray-addressed destination, and releases on last, beat limit or stall.
module bus_arbiter #(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int unsigned N_PORTS = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               busy_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   dest_q;
    logic [N_PORTS-1:0] grant_q;
    logic [CNT_W-1:0]   beats_q;
    logic [CNT_W-1:0]   stall_q;
    logic               terr_q;

    logic [IDX_W-1:0]   pick_c;
    logic               pick_valid_c;
    logic [BYTE_W-1:0]  bus_data_c;
    logic [IDX_W-1:0]   dest_c;
    logic               src_valid_g_c;
    logic               src_last_g_c;
    logic               beat_c;
    logic [CNT_W-1:0]   beats_next_c;
    logic               end_c;
    logic               abort_c;

    // Gray-coded destination field: 00->0, 01->1, 11->2, 10->3
    function automatic logic [IDX_W-1:0] gray_dest(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // First requester at or above ptr, wrapping 3->0
    always_comb begin
        pick_c       = ptr_q;
        pick_valid_c = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!pick_valid_c && bus.req[IDX_W'(ptr_q + IDX_W'(i))]) begin
                pick_c       = IDX_W'(ptr_q + IDX_W'(i));
                pick_valid_c = 1'b1;
            end
        end
    end

    // Granted source's byte and handshake; destination is live from the header until it is accepted
    always_comb begin
        bus_data_c = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                bus_data_c = bus.src_data[i*BYTE_W +: BYTE_W];
            end
        end
        src_valid_g_c = |(bus.src_valid & grant_q);
        src_last_g_c  = |(bus.src_last & grant_q);
        dest_c        = (state_q == HEAD) ? gray_dest(bus_data_c[7:6]) : dest_q;
        beat_c        = (state_q != IDLE) && src_valid_g_c && bus.dst_ready[dest_c];
        beats_next_c  = (state_q == HEAD) ? CNT_W'(1) : CNT_W'(beats_q + CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state logic; a beat always takes priority over the stall limit
    always_comb begin
        state_d = state_q;
        end_c   = 1'b0;
        abort_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d = HEAD;
                end
            end
            HEAD, XFER: begin
                if (beat_c) begin
                    if (src_last_g_c || (beats_next_c == CNT_W'(MAX_BEATS))) begin
                        end_c   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else if (stall_q == CNT_W'(TIMEOUT - 1)) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs, combinational from grant, source/destination handshakes and latched destination
    always_comb begin
        bus.bus_data  = '0;
        bus.dst_valid = '0;
        bus.src_ready = '0;
        if (state_q != IDLE) begin
            bus.bus_data = bus_data_c;
            if (src_valid_g_c) begin
                bus.dst_valid = N_PORTS'(1) << dest_c;
            end
            bus.src_ready = grant_q & {N_PORTS{bus.dst_ready[dest_c]}};
        end
    end

    // Grant, pointer, destination latch and beat/stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            dest_q  <= '0;
            beats_q <= '0;
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= abort_c;
            if (state_q == IDLE) begin
                beats_q <= '0;
                stall_q <= '0;
                if (pick_valid_c) begin
                    gidx_q  <= pick_c;
                    grant_q <= N_PORTS'(1) << pick_c;
                end
            end else if (end_c || abort_c) begin
                grant_q <= '0;
                ptr_q   <= IDX_W'(gidx_q + IDX_W'(1));
                beats_q <= '0;
                stall_q <= '0;
            end else if (beat_c) begin
                beats_q <= beats_next_c;
                stall_q <= '0;
                if (state_q == HEAD) begin
                    dest_q <= dest_c;
                end
            end else begin
                stall_q <= CNT_W'(stall_q + CNT_W'(1));
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, every cycle compared against
// a transaction-level model of owner / pointer / destination / beat and stall counts.
module tb_bus_arbiter;
    localparam int MAXB = 4;
    localparam int TMO  = 15;

    logic clk = 1'b0;
    logic reset;

    bus_arbiter_if bus_if ();

    bus_arbiter #(.MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-source byte streams: bit 8 marks the last byte of a packet
    logic [8:0] smem [4][256];
    int         wr_p [4];
    int         rd_p [4];
    logic [3:0] req_force;
    logic [3:0] vmask;
    logic [3:0] dready;

    // Reference model: owner -1 means bus free, dest -1 means header not yet accepted
    int m_owner;
    int m_ptr;
    int m_dest;
    int m_beats;
    int m_stall;
    bit m_terr;

    logic [3:0]  s_grant;
    logic [3:0]  prev_grant;
    logic        s_terr;
    byte unsigned beat_log [$];
    int           grant_log [$];

    function automatic int gray(input logic [1:0] b);
        case (b)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit pending(input int i);
        return rd_p[i] != wr_p[i];
    endfunction

    task automatic push(input int i, input logic [7:0] d, input bit last);
        smem[i][wr_p[i] % 256] = {last, d};
        wr_p[i]++;
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) rd_p[i] = wr_p[i];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            e = smem[i][rd_p[i] % 256];
            if (pending(i)) begin
                bus_if.src_valid[i]        = vmask[i];
                bus_if.src_last[i]         = e[8];
                bus_if.src_data[i*8 +: 8]  = e[7:0];
            end else begin
                bus_if.src_valid[i]        = 1'b0;
                bus_if.src_last[i]         = 1'($urandom_range(0, 1));
                bus_if.src_data[i*8 +: 8]  = 8'($urandom);
            end
            bus_if.req[i] = req_force[i] | pending(i);
        end
        bus_if.dst_ready = dready;
    endtask

    // Advance the model across one rising edge using the inputs that were on the bus
    task automatic step();
        int d;
        bit beat;
        m_terr = 1'b0;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_dest = -1; m_beats = 0; m_stall = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && bus_if.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            m_dest = -1; m_beats = 0; m_stall = 0;
        end else begin
            d    = (m_dest >= 0) ? m_dest : gray(bus_if.src_data[m_owner*8 + 6 +: 2]);
            beat = bus_if.src_valid[m_owner] && bus_if.dst_ready[d];
            if (beat) begin
                rd_p[m_owner]++;
                m_beats++;
                m_stall = 0;
                if (m_dest < 0) m_dest = d;
                if (bus_if.src_last[m_owner] || m_beats == MAXB) begin
                    m_ptr = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end else begin
                m_stall++;
                if (m_stall == TMO) begin
                    m_terr = 1'b1;
                    m_ptr = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end
        end
    endtask

    // One clock: drive, compare mid-cycle, then step the model over the edge
    task automatic tick();
        logic [3:0] e_grant, e_dv, e_sr;
        logic [7:0] e_bus;
        int d;
        drive();
        #1;
        e_grant = '0; e_dv = '0; e_sr = '0; e_bus = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_bus = bus_if.src_data[m_owner*8 +: 8];
            d = (m_dest >= 0) ? m_dest : gray(e_bus[7:6]);
            if (bus_if.src_valid[m_owner]) e_dv[d] = 1'b1;
            if (bus_if.dst_ready[d]) e_sr[m_owner] = 1'b1;
        end
        chk("grant",       32'(bus_if.grant),       32'(e_grant));
        chk("busy",        32'(bus_if.busy),        32'(m_owner >= 0));
        chk("bus_data",    32'(bus_if.bus_data),    32'(e_bus));
        chk("dst_valid",   32'(bus_if.dst_valid),   32'(e_dv));
        chk("src_ready",   32'(bus_if.src_ready),   32'(e_sr));
        chk("timeout_err", 32'(bus_if.timeout_err), 32'(m_terr));
        s_grant = bus_if.grant;
        s_terr  = bus_if.timeout_err;
        if (s_grant != 4'b0 && prev_grant == 4'b0) grant_log.push_back(int'(s_grant));
        prev_grant = s_grant;
        if ((bus_if.dst_valid & bus_if.dst_ready) != 4'b0) beat_log.push_back(bus_if.bus_data);
        @(posedge clk);
        step();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kg, ke;
        logic [3:0] pat;
        reset = 1'b1;
        req_force = '0; vmask = 4'hF; dready = 4'hF; prev_grant = '0;
        for (int i = 0; i < 4; i++) begin wr_p[i] = 0; rd_p[i] = 0; end
        m_owner = -1; m_ptr = 0; m_dest = -1; m_beats = 0; m_stall = 0; m_terr = 1'b0;
        bus_if.req = '0; bus_if.src_valid = '0; bus_if.src_last = '0;
        bus_if.src_data = '0; bus_if.dst_ready = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Single transfer: source 1 to destination 1
        beat_log.delete(); grant_log.delete();
        push(1, 8'h40, 1'b0); push(1, 8'hAA, 1'b0); push(1, 8'h55, 1'b1);
        repeat (8) tick();
        chk("s1_nbeats", 32'(beat_log.size()), 32'd3);
        chk("s1_b0", 32'(beat_log[0]), 32'h40);
        chk("s1_b1", 32'(beat_log[1]), 32'hAA);
        chk("s1_b2", 32'(beat_log[2]), 32'h55);
        chk("s1_grant", 32'(grant_log[0]), 32'b0010);

        // Round robin with all four requesting single-byte packets
        reset_pulse();
        beat_log.delete(); grant_log.delete();
        push(0, 8'h00, 1'b1); push(0, 8'h00, 1'b1); push(1, 8'h40, 1'b1);
        push(2, 8'hC0, 1'b1); push(3, 8'h80, 1'b1);
        repeat (14) tick();
        chk("rr_n",  32'(grant_log.size()), 32'd5);
        chk("rr_g0", 32'(grant_log[0]), 32'b0001);
        chk("rr_g1", 32'(grant_log[1]), 32'b0010);
        chk("rr_g2", 32'(grant_log[2]), 32'b0100);
        chk("rr_g3", 32'(grant_log[3]), 32'b1000);
        chk("rr_g4", 32'(grant_log[4]), 32'b0001);

        // Backpressure from destination 3 while source 2 sends
        beat_log.delete(); grant_log.delete();
        pat = 4'b1001;
        push(2, 8'h80, 1'b0); push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b1);
        for (int k = 0; k < 12; k++) begin
            dready = {pat[k % 4], 3'b111};
            tick();
        end
        dready = 4'hF;
        chk("bp_nbeats", 32'(beat_log.size()), 32'd3);
        chk("bp_b0", 32'(beat_log[0]), 32'h80);
        chk("bp_b1", 32'(beat_log[1]), 32'h11);
        chk("bp_b2", 32'(beat_log[2]), 32'h22);

        // Beat limit: source 0 streams 6 bytes without last
        reset_pulse();
        beat_log.delete(); grant_log.delete();
        for (int k = 1; k <= 6; k++) push(0, 8'(k), 1'b0);
        push(1, 8'h40, 1'b1); push(2, 8'hC0, 1'b1);
        repeat (32) tick();
        chk("fe_g0", 32'(grant_log[0]), 32'b0001);
        chk("fe_g1", 32'(grant_log[1]), 32'b0010);
        chk("fe_g2", 32'(grant_log[2]), 32'b0100);
        chk("fe_g3", 32'(grant_log[3]), 32'b0001);
        chk("fe_nbeats", 32'(beat_log.size()), 32'd8);

        // Stall abort on source 3, then pointer wraps to source 0
        reset_pulse();
        push(2, 8'h00, 1'b1);
        repeat (4) tick();
        grant_log.delete();
        push(0, 8'h00, 1'b1);
        req_force = 4'b1000;
        kg = -1000; ke = -2000;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (s_grant == 4'b1000 && kg < 0) kg = k;
            if (s_terr && ke < 0) ke = k;
            if (s_grant == 4'b0001) req_force = 4'b0000;
        end
        chk("tmo_latency", 32'(ke - kg), 32'd15);
        chk("tmo_first", 32'(grant_log[0]), 32'b1000);
        chk("tmo_next",  32'(grant_log[1]), 32'b0001);

        // Reset in the middle of a transfer after two accepted beats
        push(2, 8'h00, 1'b1);
        repeat (4) tick();
        beat_log.delete();
        for (int k = 0; k < 5; k++) push(1, 8'(8'h10 + k), 1'b0);
        for (int k = 0; k < 20 && beat_log.size() < 2; k++) tick();
        chk("mr_beats", 32'(beat_log.size()), 32'd2);
        reset_pulse();
        tick();
        chk("mr_grant0", 32'(s_grant), 32'd0);
        grant_log.delete();
        push(1, 8'h00, 1'b1); push(3, 8'h00, 1'b1);
        repeat (6) tick();
        chk("mr_next", 32'(grant_log[0]), 32'b0010);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            req_force = 4'($urandom) & 4'($urandom) & 4'($urandom);
            vmask     = 4'($urandom) | 4'($urandom);
            dready    = 4'($urandom) | 4'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if ((wr_p[i] - rd_p[i]) < 12 && $urandom_range(0, 3) == 0)
                    push(i, 8'($urandom), 1'($urandom_range(0, 3) == 0));
            end
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
